// File: rtl/mc_cpu.sv
// mc_cpu: multicycle MIPS-subset core with one unified memory port.
// The memory port uses a req/ready handshake, so the memory may insert wait states.
// Supported instructions: add, sub, and, or, slt, addi, lw, sw, beq, bne and j.
// The core halts on an illegal instruction and stays halted until reset.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   mem_req    access request (decoded from state)
//   mem_we     1 = write, valid while mem_req
//   mem_addr   word address (byte address bits [MEM_AW+1:2])
//   mem_wdata  store data
//   mem_rdata  read data, valid in the cycle where mem_ready=1
//   mem_ready  the access completes at this rising edge
//   halted     core stopped on an illegal instruction
//   pc_out     current PC (debug)
module mc_cpu #(
   parameter int unsigned MEM_AW   = 9,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic [31:0]       pc_out
);

   localparam int unsigned NREG = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      S_INIT, S_FETCH, S_DECODE, S_EXEC, S_RWB, S_ADDI, S_IWB,
      S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] rf_q [NREG];
   logic [31:0] rf_d [NREG];

   // Instruction fields
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sext;
   logic        rtype_ok;
   logic [31:0] alu_res;

   assign op       = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

   // R-type ALU and the check for a legal funct field
   always_comb begin
      rtype_ok = 1'b1;
      alu_res  = '0;
      case (funct)
         FN_ADD:  alu_res = a_q + b_q;
         FN_SUB:  alu_res = a_q - b_q;
         FN_AND:  alu_res = a_q & b_q;
         FN_OR:   alu_res = a_q | b_q;
         FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
         default: rtype_ok = 1'b0;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_INIT;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         mdr_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= '0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         alu_q   <= alu_d;
         for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_RTYPE:      state_d = rtype_ok ? S_EXEC : S_HALT;
               OP_ADDI:       state_d = S_ADDI;
               OP_LW, OP_SW:  state_d = S_MEMADR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               default:       state_d = S_HALT;
            endcase
         end
         S_EXEC:   state_d = S_RWB;
         S_ADDI:   state_d = S_IWB;
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_RWB, S_IWB, S_MEMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_HALT;
      endcase
   end

   // Memory port and status outputs. These depend only on registers, so they
   // stay stable during wait states and drop as soon as reset is asserted.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = alu_q[MEM_AW+1:2];
      mem_wdata = b_q;
      halted    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc_q[MEM_AW+1:2];
         end
         S_MEMRD: mem_req = 1'b1;
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   assign pc_out = pc_q;

   // Datapath register updates for each state
   always_comb begin
      pc_d  = pc_q;
      ir_d  = ir_q;
      mdr_d = mdr_q;
      a_d   = a_q;
      b_d   = b_q;
      alu_d = alu_q;
      for (int i = 0; i < NREG; i++) rf_d[i] = rf_q[i];
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d = mem_rdata;
               pc_d = pc_q + 32'd4;
            end
         end
         S_DECODE: begin
            a_d   = rf_q[rs];
            b_d   = rf_q[rt];
            // The branch target is computed early; pc_q already points past this instruction.
            alu_d = pc_q + {imm_sext[29:0], 2'b00};
         end
         S_EXEC:   alu_d = alu_res;
         S_ADDI, S_MEMADR: alu_d = a_q + imm_sext;
         S_RWB:    rf_d[rd] = alu_q;
         S_IWB:    rf_d[rt] = alu_q;
         S_MEMRD:  if (mem_ready) mdr_d = mem_rdata;
         S_MEMWB:  rf_d[rt] = mdr_q;
         S_BRANCH: begin
            if ((op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q)) pc_d = alu_q;
         end
         S_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
         default: ;
      endcase
      // $0 is hardwired to zero
      rf_d[0] = '0;
   end

endmodule

// File: tb/tb_mc_cpu.sv
// Directed testbench for mc_cpu. It uses a memory model with a programmable
// wait-state count and a transfer log.
module tb_mc_cpu;
   localparam int unsigned MEM_AW = 9;
   localparam int unsigned DEPTH  = 1 << MEM_AW;
   localparam int unsigned LOGN   = 64;

   logic              clk;
   logic              reset;
   logic              mem_req, mem_we, mem_ready, halted;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata, pc_out;

   mc_cpu #(.MEM_AW(MEM_AW), .RESET_PC(32'h0000_0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .halted    (halted),
      .pc_out    (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ready is held low for wait_cfg cycles of each request
   logic [31:0]       mem [DEPTH];
   int unsigned       wait_cfg, wcnt, cyc;
   logic              mem_clr, load_en, log_clr;
   logic [MEM_AW-1:0] load_addr;
   logic [31:0]       load_data;
   int unsigned       n_xfer, n_wr, unstable;
   int unsigned       x_cyc  [LOGN];
   logic [MEM_AW-1:0] x_addr [LOGN];
   logic              x_we   [LOGN];
   logic [31:0]       x_data [LOGN];
   logic              p_wait, p_we;
   logic [MEM_AW-1:0] p_addr;
   logic [31:0]       p_wdata;

   assign mem_ready = mem_req && (wcnt >= wait_cfg);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      cyc <= reset ? cyc + 1 : 0;
      wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
      // Outputs must hold while a request waits, including on the completing cycle
      if (mem_req && p_wait &&
          (mem_addr != p_addr || mem_we != p_we || (mem_we && mem_wdata != p_wdata)))
         unstable <= unstable + 1;
      p_wait  <= mem_req && !mem_ready;
      p_addr  <= mem_addr;
      p_we    <= mem_we;
      p_wdata <= mem_wdata;
      if (mem_clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (load_en) begin
         mem[load_addr] <= load_data;
      end else if (mem_req && mem_ready && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      if (log_clr) begin
         n_xfer   <= 0;
         n_wr     <= 0;
         unstable <= 0;
      end else if (mem_req && mem_ready) begin
         if (n_xfer < LOGN) begin
            x_cyc[n_xfer]  <= cyc + 1;
            x_addr[n_xfer] <= mem_addr;
            x_we[n_xfer]   <= mem_we;
            x_data[n_xfer] <= mem_we ? mem_wdata : mem_rdata;
         end
         n_xfer <= n_xfer + 1;
         if (mem_we) n_wr <= n_wr + 1;
      end
   end

   int unsigned n_chk, n_fail;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic load_word(input int unsigned addr, input logic [31:0] data);
      load_addr = MEM_AW'(addr);
      load_data = data;
      load_en   = 1'b1;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   // Assert reset, clear memory and the log, and set the wait-state count
   task automatic start_test(input int unsigned wcfg);
      reset    = 1'b0;
      wait_cfg = wcfg;
      log_clr  = 1'b1;
      mem_clr  = 1'b1;
      @(negedge clk);
      mem_clr  = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      log_clr = 1'b0;
      reset   = 1'b1;
   endtask

   task automatic wait_xfers(input string tag, input int unsigned n, input int unsigned budget);
      int unsigned k = 0;
      while (n_xfer < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_val(tag, 32'(n_xfer >= n ? n : n_xfer), 32'(n));
   endtask

   initial begin
      int unsigned base, k;
      n_chk = 0; n_fail = 0;
      reset = 1'b0; mem_clr = 1'b0; load_en = 1'b0; log_clr = 1'b1;
      load_addr = '0; load_data = '0; wait_cfg = 0;
      wcnt = 0; cyc = 0; n_xfer = 0; n_wr = 0; unstable = 0; p_wait = 1'b0;
      p_we = 1'b0; p_addr = '0; p_wdata = '0;
      repeat (2) @(negedge clk);

      // Test 1: arithmetic plus store, zero wait, then an illegal instruction
      start_test(0);
      load_word(0, 32'h2001_0005);   // addi $1,$0,5
      load_word(1, 32'h2002_0007);   // addi $2,$0,7
      load_word(2, 32'h0022_1820);   // add  $3,$1,$2
      load_word(3, 32'hAC03_0008);   // sw   $3,8($0)
      load_word(4, 32'hFC00_0000);   // opcode 0x3F, illegal
      check_val("rst_req", 32'(mem_req), 32'd0);
      check_val("rst_we", 32'(mem_we), 32'd0);
      check_val("rst_halted", 32'(halted), 32'd0);
      check_val("rst_pc", pc_out, 32'h0);
      release_reset();
      #1 check_val("init_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      check_val("first_req", 32'(mem_req), 32'd1);
      check_val("first_addr", 32'(mem_addr), 32'd0);
      wait_xfers("t1_xfers", 6, 100);
      check_val("t1_first_cyc", x_cyc[0], 32'd2);
      check_val("t1_sw_we", 32'(x_we[4]), 32'd1);
      check_val("t1_sw_addr", 32'(x_addr[4]), 32'd2);
      check_val("t1_sw_data", x_data[4], 32'd12);
      check_val("t1_fetch10", 32'(x_addr[5]), 32'd4);
      check_val("t1_cycles16", x_cyc[5] - x_cyc[0], 32'd16);
      check_val("t1_mem2", mem[2], 32'd12);
      check_val("halt_not_yet", 32'(halted), 32'd0);
      @(negedge clk);
      check_val("halt_after_decode", 32'(halted), 32'd1);
      repeat (10) @(negedge clk);
      check_val("halt_held", 32'(halted), 32'd1);
      check_val("halt_no_req", 32'(mem_req), 32'd0);
      check_val("halt_pc", pc_out, 32'h14);
      check_val("halt_no_xfer", 32'(n_xfer), 32'd6);

      // Test 2: lw with 3 wait states per access, then a store of the result
      start_test(3);
      load_word(0, 32'h8C04_0008);   // lw $4,8($0)
      load_word(1, 32'hAC04_0010);   // sw $4,16($0)
      load_word(2, 32'h0000_000C);   // data 12; as an instruction, an illegal funct
      release_reset();
      wait_xfers("t2_xfers", 4, 200);
      check_val("t2_first_cyc", x_cyc[0], 32'd5);
      check_val("t2_lw_addr", 32'(x_addr[1]), 32'd2);
      check_val("t2_lw_we", 32'(x_we[1]), 32'd0);
      check_val("t2_lw_cyc", x_cyc[1], 32'd11);
      check_val("t2_cycles11", x_cyc[2] - x_cyc[0], 32'd11);
      check_val("t2_sw_addr", 32'(x_addr[3]), 32'd4);
      check_val("t2_sw_data", x_data[3], 32'd12);
      check_val("t2_mem4", mem[4], 32'd12);
      check_val("t2_stable", unstable, 32'd0);

      // Test 3: bne not taken, addi to $0, j, beq taken, and a store of $0
      start_test(0);
      load_word(0,  32'h2001_0005);  // addi $1,$0,5
      load_word(1,  32'h2002_0005);  // addi $2,$0,5
      load_word(2,  32'h1422_0002);  // bne  $1,$2,+2  (not taken)
      load_word(3,  32'h2000_0009);  // addi $0,$0,9
      load_word(4,  32'h0800_0040);  // j    0x40 -> byte 0x100
      load_word(5,  32'hDEAD_BEEF);
      load_word(64, 32'h1022_0002);  // beq  $1,$2,+2  (taken -> 0x10C)
      load_word(67, 32'hAC00_0014);  // sw   $0,20($0)
      release_reset();
      wait_xfers("t3_xfers", 9, 100);
      check_val("bne_next", 32'(x_addr[3]), 32'd3);
      check_val("bne_cycles", x_cyc[3] - x_cyc[2], 32'd3);
      check_val("j_target", 32'(x_addr[5]), 32'd64);
      check_val("j_cycles", x_cyc[5] - x_cyc[4], 32'd3);
      check_val("beq_target", 32'(x_addr[6]), 32'd67);
      check_val("beq_cycles", x_cyc[6] - x_cyc[5], 32'd3);
      check_val("r0_store_addr", 32'(x_addr[7]), 32'd5);
      check_val("r0_store_data", x_data[7], 32'd0);
      check_val("r0_mem5", mem[5], 32'd0);

      // Test 4: reset asserted in the middle of a waiting store
      start_test(5);
      load_word(0, 32'h2001_0055);   // addi $1,$0,0x55
      load_word(1, 32'hAC01_0028);   // sw   $1,40($0) -> word 10
      release_reset();
      k = 0;
      while (!(mem_req && mem_we) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_val("t4_reach_memwr", 32'(mem_req && mem_we), 32'd1);
      @(negedge clk);
      check_val("t4_still_wait", 32'(mem_req && mem_we), 32'd1);
      #2 reset = 1'b0;
      #1 check_val("t4_req_drop", 32'(mem_req), 32'd0);
      repeat (3) @(negedge clk);
      check_val("t4_no_write", 32'(n_wr), 32'd0);
      check_val("t4_mem10", mem[10], 32'd0);
      base = n_xfer;
      reset = 1'b1;
      wait_xfers("t4_refetch", base + 1, 50);
      check_val("t4_restart_pc", 32'(x_addr[base]), 32'd0);
      wait_xfers("t4_rerun", base + 3, 100);
      check_val("t4_store_after", mem[10], 32'h55);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mc_cpu.md
# mc_cpu

Parametrised multicycle MIPS-subset core with a single unified memory port under a req/ready handshake, so slow or shared memories can stall it. It contains the PC, instruction/data registers, 32×32 register file, ALU and the control FSM, and replaces the fixed zero-wait multicycle top. It adds `bne`/`addi`/`slt`, wait-state tolerance and halt-on-illegal.

## Interface
Parameters:
- MEM_AW, 9, word-address width of the memory port.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_req  output  1  access request.
- mem_we  output  1  1 = write, valid while mem_req.
- mem_addr  output  MEM_AW  word address, byte address bits [MEM_AW+1:2].
- mem_wdata  output  32  store data.
- mem_rdata  input  32  read data, valid in the cycle mem_ready=1.
- mem_ready  input  1  access completes at this rising edge.
- halted  output  1  core stopped on an illegal instruction.
- pc_out  output  32  current PC (debug).

## Operation
- Instructions:
  - R-type funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - Opcodes 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j.
  - Any other opcode or R-type funct is illegal.
- Arithmetic is 32-bit wrap-around. Overflow is ignored. The immediate is sign-extended.
- Register $0 reads 0. Writes to $0 are discarded.
- Byte address low 2 bits are ignored. Addresses above the port width alias.
- FSM states and transitions:
  - INIT: go to FETCH.
  - FETCH: mem_req=1, addr=PC. On mem_ready: IR←rdata, PC←PC+4, go to DECODE.
  - DECODE: A←rs, B←rt, ALUOut←PC+(sext(imm)<<2). Dispatch on opcode.
  - EXEC → RWB: rd←ALU(A,B).
  - ADDI → IWB: rt←A+sext(imm).
  - MEMADR: ALUOut←A+sext(imm), then go to MEMRD (lw) or MEMWR (sw).
  - MEMRD: mem_req=1, we=0. On ready, MDR←rdata, go to MEMWB.
  - MEMWB: rt←MDR.
  - MEMWR: mem_req=1, we=1, wdata=B. On ready, go to FETCH.
  - BRANCH: beq taken if A==B, bne taken if A!=B. If taken, PC←ALUOut. Go to FETCH.
  - JUMP: PC←{PC[31:28], imm26, 2'b00}. Go to FETCH.
  - Illegal instruction: go to HALT.
  - HALT: halted=1, no requests, no state change until reset.
- RWB, IWB and MEMWB return to FETCH.
- mem_req, mem_we, mem_addr and mem_wdata are decoded from state plus registers. They stay stable while waiting for ready.

## Timing
- Reset asserted:
  - state=INIT, PC=RESET_PC, all registers 0.
  - mem_req=0, mem_we=0, halted=0, pc_out=RESET_PC.
- The first request appears 1 cycle after reset deasserts (at the edge out of INIT).
- Zero-wait cycle counts, FETCH entry to next FETCH entry:
  - R-type 4, addi 4, sw 4, lw 5, beq/bne 3, j 3.
  - Each cycle mem_ready=0 during FETCH, MEMRD or MEMWR adds 1.
- A transfer completes only at an edge where mem_req=1 and mem_ready=1. mem_ready while mem_req=0 is ignored.
- Back-to-back requests are allowed. mem_req may stay high from MEMWR into FETCH.
- Reset mid-access:
  - mem_req drops asynchronously.
  - A pending store is abandoned and no register write occurs.
  - Execution restarts at RESET_PC.
- Register-file writes occur at the rising edge ending RWB, IWB or MEMWB. A source read in the following DECODE sees the new value.
- halted rises at the edge that enters HALT and stays high until reset.

## Test plan
- Zero-wait memory, RESET_PC=0, program `addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,8($0)` → 16 cycles from the first FETCH, mem word 2 = 12, then the fetch at byte address 0x10.
- `lw $4,8($0)` with mem_ready held low 3 cycles in both FETCH and MEMRD → $4=12 after 11 cycles. mem_addr and mem_we stay stable through the waits.
- $1=$2=5: `beq $1,$2,+2` → next fetch at PC+12. `bne $1,$2,+2` → next fetch at PC+4. Each takes 3 cycles.
- `j 0x40` at 0x10 → next fetch at byte 0x100. `addi $0,$0,9` → $0 still reads 0.
- Opcode 0x3F → halted=1 after DECODE, mem_req=0 for all following cycles, pc_out frozen.
- Pull reset low during a MEMWR with mem_ready=0, then release → mem_req=0 immediately, no write reaches memory, the next fetch is at RESET_PC.
